// File: rtl/fscale_pow2_ctrl_pkg.sv
// Shared types and helpers for the fscale_pow2_ctrl power-of-two scaler.
package fscale_pow2_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a requester count, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fscale_pow2_ctrl_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arb
  import fscale_pow2_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fscale_pow2_ctrl.sv
// Shared halve-by-two datapath computing x/2^k for NREQ round-robin requesters.
// Define FSCALE_FTZ_EN to flush subnormal inputs and intermediates to signed zero.
module fscale_pow2_ctrl
  import fscale_pow2_ctrl_pkg::*;
#(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 7,
  parameter int I_DATA = I_EXP + I_MNT + 1,
  parameter int NREQ   = 2,
  parameter int SHW    = 5,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_vld,
  output logic [NREQ-1:0]        req_rdy,
  input  logic [NREQ*I_DATA-1:0] req_data,
  input  logic [NREQ*SHW-1:0]    req_shift,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [I_DATA-1:0]      rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  localparam int EXP_HI = I_DATA - 2;
  localparam logic [I_EXP-1:0]  EXP_ONES = '1;
  localparam logic [I_EXP-1:0]  EXP_ONE  = I_EXP'(1);
  localparam logic [I_DATA-2:0] ZERO_MAG = '0;
  localparam logic [SHW-1:0]    CNT_ONE  = SHW'(1);
  localparam logic [IDW-1:0]    IDX_ONE  = IDW'(1);

  // Exact halving; a value entering the subnormal range loses its mantissa LSB.
  function automatic logic [I_DATA-1:0] fdiv2(input logic [I_DATA-1:0] x);
    logic [I_EXP-1:0] e;
    logic [I_MNT-1:0] m;
    e = x[EXP_HI -: I_EXP];
    m = x[I_MNT-1:0];
    if (e == EXP_ONES)
      fdiv2 = x;
    else if (e > EXP_ONE)
      fdiv2 = {x[I_DATA-1], e - EXP_ONE, m};
    else if (e == EXP_ONE)
      fdiv2 = {x[I_DATA-1], {I_EXP{1'b0}}, 1'b1, m[I_MNT-1:1]};
    else
      fdiv2 = {x[I_DATA-1], {I_EXP{1'b0}}, 1'b0, m[I_MNT-1:1]};
  endfunction

  state_t            state;
  logic [I_DATA-1:0] acc;
  logic [SHW-1:0]    cnt;
  logic [IDW-1:0]    rr_ptr;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic [IDW-1:0]    next_ptr;
  logic [I_DATA-1:0] sel_data;
  logic [SHW-1:0]    sel_shift;
  logic              sel_zero;
  logic              sel_pass;
  logic [I_DATA-1:0] half;
  logic              half_zero;
  logic              idle_flush;
  logic              step_flush;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_vld),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_rdy = (state == ST_IDLE) ? grant : '0;

  always_comb begin
    sel_data  = '0;
    sel_shift = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[i*I_DATA +: I_DATA];
        sel_shift = req_shift[i*SHW +: SHW];
      end
    end
  end

  always_comb begin
    if (int'(grant_idx) == NREQ - 1)
      next_ptr = '0;
    else
      next_ptr = grant_idx + IDX_ONE;
  end

  assign sel_zero  = (sel_data[I_DATA-2:0] == ZERO_MAG);
  assign sel_pass  = (sel_shift == '0) || (sel_data[EXP_HI -: I_EXP] == EXP_ONES) || sel_zero;
  assign half      = fdiv2(acc);
  assign half_zero = (half[I_DATA-2:0] == ZERO_MAG);

`ifdef FSCALE_FTZ_EN
  assign idle_flush = (sel_data[EXP_HI -: I_EXP] == '0) && !sel_zero;
  assign step_flush = (half[EXP_HI -: I_EXP] == '0);
`else
  assign idle_flush = 1'b0;
  assign step_flush = 1'b0;
`endif

  // Response fields are loaded only on entry to DONE so they hold through backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      acc      <= '0;
      cnt      <= '0;
      rr_ptr   <= '0;
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            rsp_id <= grant_idx;
            rr_ptr <= next_ptr;
            cnt    <= sel_shift;
            busy   <= 1'b1;
            if (sel_pass) begin
              acc      <= sel_data;
              rsp_data <= sel_data;
              rsp_vld  <= 1'b1;
              state    <= ST_DONE;
            end else if (idle_flush) begin
              acc      <= {sel_data[I_DATA-1], ZERO_MAG};
              rsp_data <= {sel_data[I_DATA-1], ZERO_MAG};
              rsp_vld  <= 1'b1;
              state    <= ST_DONE;
            end else begin
              acc   <= sel_data;
              state <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          cnt <= cnt - CNT_ONE;
          if (step_flush) begin
            acc      <= {half[I_DATA-1], ZERO_MAG};
            rsp_data <= {half[I_DATA-1], ZERO_MAG};
            rsp_vld  <= 1'b1;
            state    <= ST_DONE;
          end else begin
            acc <= half;
            // Once the magnitude reaches zero further halving changes nothing.
            if ((cnt == CNT_ONE) || half_zero) begin
              rsp_data <= half;
              rsp_vld  <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          rsp_vld <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fscale_pow2_ctrl.sv
// Self-checking bench for fscale_pow2_ctrl against a value-level x/2^k reference model.
module tb_fscale_pow2_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_vld;
  logic [1:0]  req_rdy;
  logic [31:0] req_data;
  logic [9:0]  req_shift;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [15:0] rsp_data;
  logic [0:0]  rsp_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fscale_pow2_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_data  (req_data),
    .req_shift (req_shift),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Value of x/2^k: scale the integer significand, truncating bits shifted below the subnormal LSB.
  function automatic logic [15:0] ref_scale(input logic [15:0] x, input int k);
    int e, sig, eeff, new_e, sh;
    e = int'(x[14:7]);
    if (k == 0 || e == 255 || x[14:0] == 15'd0) return x;
`ifdef FSCALE_FTZ_EN
    if (e == 0) return {x[15], 15'd0};
`endif
    sig   = (e != 0) ? 128 + int'(x[6:0]) : int'(x[6:0]);
    eeff  = (e != 0) ? e : 1;
    new_e = eeff - k;
    if (new_e >= 1) return {x[15], 8'(new_e), 7'(sig - 128)};
`ifdef FSCALE_FTZ_EN
    return {x[15], 15'd0};
`else
    sh  = 1 - new_e;
    sig = (sh >= 8) ? 0 : (sig >> sh);
    return {x[15], 8'd0, 7'(sig)};
`endif
  endfunction

  // Cycles from transfer to rsp_vld: 1 + halvings performed before the result settles.
  function automatic int ref_latency(input logic [15:0] x, input int k);
    logic [15:0] r;
    if (k == 0 || x[14:7] == 8'hFF || x[14:0] == 15'd0) return 1;
`ifdef FSCALE_FTZ_EN
    if (x[14:7] == 8'd0) return 1;
`endif
    for (int n = 1; n <= k; n++) begin
      r = ref_scale(x, n);
      if (r[14:0] == 15'd0) return 1 + n;
    end
    return 1 + k;
  endfunction

  function automatic logic [15:0] rand_operand();
    logic [7:0]  e;
    logic [15:0] v;
    case ($urandom_range(0, 6))
      0:       e = 8'd0;
      1:       e = 8'd1;
      2:       e = 8'($urandom_range(2, 10));
      3:       e = 8'hFF;
      default: e = 8'($urandom_range(0, 254));
    endcase
    v = {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    if ($urandom_range(0, 15) == 0) v[14:0] = 15'd0;
    return v;
  endfunction

  task automatic do_op(input int id, input logic [15:0] x, input int k, input string tag);
    logic [15:0] want;
    int want_lat, waited, lat;
    want     = ref_scale(x, k);
    want_lat = ref_latency(x, k);
    req_data[id*16 +: 16] = x;
    req_shift[id*5 +: 5]  = k[4:0];
    req_vld[id]           = 1'b1;
    #1;
    waited = 0;
    while (!req_rdy[id] && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (!req_rdy[id]) begin
      bad++;
      $display("[TB] FAIL %s grant: req_rdy=%b, needed bit %0d", tag, req_rdy, id);
      req_vld[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_vld[id] = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != want_lat) begin
      bad++;
      $display("[TB] FAIL %s latency: got %0d want %0d (x=%h k=%0d)", tag, lat, want_lat, x, k);
    end
    total++;
    if (rsp_data !== want) begin
      bad++;
      $display("[TB] FAIL %s data: got %h want %h (x=%h k=%0d)", tag, rsp_data, want, x, k);
    end
    total++;
    if (rsp_id !== 1'(id)) begin
      bad++;
      $display("[TB] FAIL %s id: got %0d want %0d", tag, rsp_id, id);
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    total++;
    if (rsp_vld !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s release: rsp_vld=%b busy=%b want 0 0", tag, rsp_vld, busy);
    end
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req_vld   = '0;
    req_data  = '0;
    req_shift = '0;
    rsp_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rsp_vld !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: rsp_vld=%b busy=%b want 0 0", rsp_vld, busy);
    end
    total++;
    if (rsp_data !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h want 0000", rsp_data);
    end
    total++;
    if (rsp_id !== 1'b0 || req_rdy !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_id_rdy: rsp_id=%0d req_rdy=%b want 0 00", rsp_id, req_rdy);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(0, 16'h3F80, 3, "one_k3");
    do_op(0, 16'h0080, 1, "min_normal");
    do_op(1, 16'h7F80, 5, "inf");
    do_op(0, 16'hFFC1, 2, "nan");
    do_op(1, 16'h8000, 9, "neg_zero");
    do_op(1, 16'h0003, 4, "subnormal_to_zero");
    do_op(0, 16'h4049, 0, "k_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_op(int'($urandom_range(0, 1)), rand_operand(), int'($urandom_range(0, 31)), "random");
  endtask

  task automatic test_fairness();
    int waited, exp_id;
    logic [15:0] want;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    req_data  = {16'hC120, 16'h4000};
    req_shift = '0;
    req_vld   = 2'b11;
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_id = r % 2;
      want   = exp_id ? 16'hC120 : 16'h4000;
      waited = 0;
      while (req_rdy == 2'b00 && waited < 20) begin
        @(posedge clk); #1;
        waited++;
      end
      total++;
      if (req_rdy !== 2'(1 << exp_id)) begin
        bad++;
        $display("[TB] FAIL fair_grant round %0d: req_rdy=%b want %b", r, req_rdy, 2'(1 << exp_id));
      end
      @(posedge clk); #1;
      total++;
      if (req_rdy !== 2'b00 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL fair_busy round %0d: req_rdy=%b busy=%b want 00 1", r, req_rdy, busy);
      end
      waited = 0;
      while (!rsp_vld && waited < 10) begin
        @(posedge clk); #1;
        waited++;
      end
      total++;
      if (rsp_vld !== 1'b1 || rsp_id !== 1'(exp_id) || rsp_data !== want) begin
        bad++;
        $display("[TB] FAIL fair_rsp round %0d: vld=%b id=%0d data=%h want 1 %0d %h",
                 r, rsp_vld, rsp_id, rsp_data, exp_id, want);
      end
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
    end
    req_vld = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] x, want;
    int waited;
    x    = 16'h4120;
    want = ref_scale(x, 2);
    req_data[31:16] = x;
    req_shift[9:5]  = 5'd2;
    req_vld         = 2'b10;
    #1;
    waited = 0;
    while (!req_rdy[1] && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    req_data[15:0] = 16'h3F80;
    req_shift[4:0] = 5'd0;
    req_vld        = 2'b01;
    waited = 0;
    while (!rsp_vld && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (rsp_vld !== 1'b1 || rsp_data !== want || rsp_id !== 1'b1 || req_rdy !== 2'b00 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL hold cycle %0d: vld=%b data=%h id=%0d rdy=%b busy=%b want 1 %h 1 00 1",
                 c, rsp_vld, rsp_data, rsp_id, req_rdy, busy, want);
      end
      @(posedge clk); #1;
    end
    req_vld = 2'b00;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    total++;
    if (rsp_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_release: rsp_vld=%b want 0", rsp_vld);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    req_data[15:0] = 16'h3F80;
    req_shift[4:0] = 5'd20;
    req_vld        = 2'b01;
    #1;
    @(posedge clk); #1;
    req_vld = 2'b00;
    repeat (5) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b1 || rsp_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_iter: busy=%b rsp_vld=%b want 1 0", busy, rsp_vld);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (rsp_vld !== 1'b0 || busy !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 1'b0 || req_rdy !== 2'b00) begin
      bad++;
      $display("[TB] FAIL async_reset: vld=%b busy=%b data=%h id=%0d rdy=%b want all zero",
               rsp_vld, busy, rsp_data, rsp_id, req_rdy);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_vld) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL dropped_op: rsp_vld seen %0d cycles want 0", seen);
    end
    do_op(0, 16'h3F80, 3, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
